// File: rtl/sprite_addr_gen.sv
// Sprite ROM address generator: hit test, ROM addressing and colour-key masking with 3-cycle latency.
// Optional horizontal mirroring is compiled in when SPRITE_FLIP_EN is defined.
module sprite_addr_gen #(
    parameter int          SPR_W       = 30,
    parameter int          SPR_H       = 40,
    parameter int          ADDR_W      = 11,
    parameter logic [5:0]  TRANSPARENT = 6'b110011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              facing_left,
    input  logic              active,
    input  logic [9:0]        col,
    input  logic [9:0]        row,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [5:0]        rom_rgb,
    output logic [5:0]        pixel_rgb,
    output logic              pixel_valid
);

    // state      | meaning
    // WAIT_FRAME | no valid position latched yet, hit suppressed
    // RUN        | position latched, sprite drawn
    typedef enum logic {
        WAIT_FRAME,
        RUN
    } state_t;

    state_t state, state_next;

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_FRAME;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_FRAME: if (frame_start) state_next = RUN;
            RUN:        state_next = RUN;
            default:    state_next = WAIT_FRAME;
        endcase
    end

    logic [9:0] x_lat;
    logic [9:0] y_lat;

`ifdef SPRITE_FLIP_EN
    logic flip_lat;
`else
    logic unused_facing;
    assign unused_facing = facing_left;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            x_lat <= '0;
            y_lat <= '0;
        end else if (frame_start) begin
            x_lat <= pos_x;
            y_lat <= pos_y;
        end
    end

`ifdef SPRITE_FLIP_EN
    always_ff @(posedge clk) begin
        if (rst)              flip_lat <= 1'b0;
        else if (frame_start) flip_lat <= facing_left;
    end
`endif

    // 11-bit bounds so a sprite near the right/bottom edge clips instead of wrapping
    logic [10:0]       x_end;
    logic [10:0]       y_end;
    logic [9:0]        dx;
    logic [9:0]        dy;
    logic [9:0]        dx_eff;
    logic              hit;
    logic [ADDR_W-1:0] addr_calc;
    logic              pix_ok;

    always_comb begin
        x_end = {1'b0, x_lat} + 11'(SPR_W);
        y_end = {1'b0, y_lat} + 11'(SPR_H);
        hit   = (state == RUN) && active
              && (col >= x_lat) && ({1'b0, col} < x_end)
              && (row >= y_lat) && ({1'b0, row} < y_end);
        dx    = col - x_lat;
        dy    = row - y_lat;
`ifdef SPRITE_FLIP_EN
        dx_eff = flip_lat ? (10'(SPR_W - 1) - dx) : dx;
`else
        dx_eff = dx;
`endif
        addr_calc = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx_eff);
    end

    logic hit_d1;
    logic hit_d2;

    assign pix_ok = hit_d2 && (rom_rgb != TRANSPARENT);

    // hit_d1/hit_d2 track the address and the ROM's registered read respectively
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr    <= '0;
            hit_d1      <= 1'b0;
            hit_d2      <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_rgb   <= '0;
        end else begin
            rom_addr    <= hit ? addr_calc : '0;
            hit_d1      <= hit;
            hit_d2      <= hit_d1;
            pixel_valid <= pix_ok;
            pixel_rgb   <= pix_ok ? rom_rgb : '0;
        end
    end

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Self-checking bench for sprite_addr_gen: registered stub ROM plus a pixel-level reference model.
module tb_sprite_addr_gen;

    localparam int         SPR_W = 30;
    localparam int         SPR_H = 40;
    localparam logic [5:0] TR    = 6'b110011;

    logic        clk = 1'b0;
    logic        rst, frame_start, facing_left, active;
    logic [9:0]  pos_x, pos_y, col, row;
    logic [10:0] rom_addr;
    logic [5:0]  rom_rgb, pixel_rgb;
    logic        pixel_valid;

    always #5 clk = ~clk;

    sprite_addr_gen dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .pos_x(pos_x), .pos_y(pos_y), .facing_left(facing_left),
        .active(active), .col(col), .row(row),
        .rom_addr(rom_addr), .rom_rgb(rom_rgb),
        .pixel_rgb(pixel_rgb), .pixel_valid(pixel_valid)
    );

    logic [5:0] rom_mem [0:SPR_W*SPR_H-1];
    always @(posedge clk) rom_rgb <= rom_mem[rom_addr];

    int checks = 0;
    int errors = 0;

    // reference model: latched position, running flag, expected pixel per input cycle
    bit         m_run;
    int         m_x, m_y;
    bit         m_flip;
    int         m_addr;
    bit         pv [3];
    logic [5:0] pr [3];

    task automatic step(input bit rs, input bit fs, input int px, input int py,
                        input bit fl, input bit act, input int c, input int r);
        int dx, dy;
        bit h;
        @(negedge clk);
        rst = rs; frame_start = fs; pos_x = 10'(px); pos_y = 10'(py);
        facing_left = fl; active = act; col = 10'(c); row = 10'(r);
        h = m_run && act && (c >= m_x) && (c < m_x + SPR_W) && (r >= m_y) && (r < m_y + SPR_H);
        if (rs) begin
            m_run = 0; m_x = 0; m_y = 0; m_flip = 0; m_addr = 0;
            for (int i = 0; i < 3; i++) begin pv[i] = 0; pr[i] = '0; end
        end else begin
            dx = c - m_x;
            dy = r - m_y;
`ifdef SPRITE_FLIP_EN
            if (m_flip) dx = SPR_W - 1 - dx;
`endif
            m_addr = h ? dy * SPR_W + dx : 0;
            pv[2] = pv[1]; pr[2] = pr[1];
            pv[1] = pv[0]; pr[1] = pr[0];
            pv[0] = h && (rom_mem[m_addr] !== TR);
            pr[0] = pv[0] ? rom_mem[m_addr] : 6'd0;
            if (fs) begin m_run = 1; m_x = px; m_y = py; m_flip = fl; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 5, 5);
        checks++;
        if (rom_addr !== 11'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", rom_addr); end
        checks++;
        if (pixel_valid !== 1'b0 || pixel_rgb !== 6'd0) begin
            errors++; $display("FAIL reset_pixel got %0b/%0h exp 0/0", pixel_valid, pixel_rgb);
        end
    endtask

    task automatic test_no_frame();
        for (int c = 90; c <= 140; c++) begin
            step(0, 0, 100, 50, 0, 1, c, 60);
            checks++;
            if (rom_addr !== 11'd0 || pixel_valid !== 1'b0) begin
                errors++; $display("FAIL no_frame col=%0d got addr %0d valid %0b exp 0/0", c, rom_addr, pixel_valid);
            end
        end
    endtask

    task automatic test_corners();
        step(0, 1, 100, 50, 0, 0, 0, 0);
        step(0, 0, 100, 50, 0, 1, 100, 50);
        checks++;
        if (rom_addr !== 11'd0) begin errors++; $display("FAIL corner_tl got %0d exp 0", rom_addr); end
        step(0, 0, 100, 50, 0, 1, 129, 89);
        checks++;
        if (rom_addr !== 11'd1199) begin errors++; $display("FAIL corner_br got %0d exp 1199", rom_addr); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 100, 50, 0, 0, 0, 0);
            checks++;
            if (pixel_valid !== pv[2] || pixel_rgb !== pr[2]) begin
                errors++; $display("FAIL corner_pixel i=%0d got %0b/%0h exp %0b/%0h", i, pixel_valid, pixel_rgb, pv[2], pr[2]);
            end
        end
    endtask

    task automatic test_transparent();
        rom_mem[4] = 6'h3F; rom_mem[5] = TR; rom_mem[6] = 6'h3F;
        step(0, 0, 100, 50, 0, 1, 104, 50);
        step(0, 0, 100, 50, 0, 1, 105, 50);
        step(0, 0, 100, 50, 0, 1, 106, 50);
        checks++;
        if (pixel_valid !== 1'b1 || pixel_rgb !== 6'h3F) begin
            errors++; $display("FAIL key_addr4 got %0b/%0h exp 1/3f", pixel_valid, pixel_rgb);
        end
        step(0, 0, 100, 50, 0, 0, 0, 0);
        checks++;
        if (pixel_valid !== 1'b0 || pixel_rgb !== 6'h00) begin
            errors++; $display("FAIL key_addr5 got %0b/%0h exp 0/0", pixel_valid, pixel_rgb);
        end
        step(0, 0, 100, 50, 0, 0, 0, 0);
        checks++;
        if (pixel_valid !== 1'b1 || pixel_rgb !== 6'h3F) begin
            errors++; $display("FAIL key_addr6 got %0b/%0h exp 1/3f", pixel_valid, pixel_rgb);
        end
    endtask

    task automatic test_right_edge();
        int hits = 0;
        step(0, 1, 620, 10, 0, 0, 0, 0);
        for (int c = 615; c <= 639; c++) begin
            step(0, 0, 620, 10, 0, 1, c, 20);
            if (rom_addr != 11'd0) hits++;
            checks++;
            if (rom_addr !== 11'(m_addr)) begin
                errors++; $display("FAIL edge_addr col=%0d got %0d exp %0d", c, rom_addr, m_addr);
            end
        end
        for (int c = 0; c <= 10; c++) begin
            step(0, 0, 620, 10, 0, 1, c, 20);
            checks++;
            if (rom_addr !== 11'd0) begin errors++; $display("FAIL edge_wrap col=%0d got %0d exp 0", c, rom_addr); end
        end
        checks++;
        if (hits != 20) begin errors++; $display("FAIL edge_hits got %0d exp 20", hits); end
    endtask

    task automatic test_midframe();
        int hits = 0;
        int first = -1;
        step(0, 1, 100, 50, 0, 0, 0, 0);
        for (int c = 95; c <= 235; c++) begin
            step(0, 0, 200, 50, 0, 1, c, 60);
            if (rom_addr != 11'd0) begin hits++; if (first < 0) first = c; end
        end
        checks++;
        if (hits != 30 || first != 100) begin
            errors++; $display("FAIL midframe_old got hits %0d first %0d exp 30/100", hits, first);
        end
        step(0, 1, 200, 50, 0, 0, 0, 0);
        hits = 0; first = -1;
        for (int c = 95; c <= 235; c++) begin
            step(0, 0, 200, 50, 0, 1, c, 60);
            if (rom_addr != 11'd0) begin hits++; if (first < 0) first = c; end
        end
        checks++;
        if (hits != 30 || first != 200) begin
            errors++; $display("FAIL midframe_new got hits %0d first %0d exp 30/200", hits, first);
        end
    endtask

    task automatic test_frame_coincide();
        step(0, 1, 400, 50, 0, 1, 205, 51);
        checks++;
        if (rom_addr !== 11'd35) begin errors++; $display("FAIL coincide_old got %0d exp 35", rom_addr); end
        step(0, 0, 400, 50, 0, 1, 205, 51);
        checks++;
        if (rom_addr !== 11'd0) begin errors++; $display("FAIL coincide_new got %0d exp 0", rom_addr); end
    endtask

    task automatic test_flip();
        step(0, 1, 300, 100, 1, 0, 0, 0);
        step(0, 0, 300, 100, 1, 1, 300, 100);
        checks++;
`ifdef SPRITE_FLIP_EN
        if (rom_addr !== 11'd29) begin errors++; $display("FAIL flip_left got %0d exp 29", rom_addr); end
`else
        if (rom_addr !== 11'd0) begin errors++; $display("FAIL flip_left got %0d exp 0", rom_addr); end
`endif
        step(0, 0, 300, 100, 1, 1, 329, 101);
        checks++;
`ifdef SPRITE_FLIP_EN
        if (rom_addr !== 11'd30) begin errors++; $display("FAIL flip_right got %0d exp 30", rom_addr); end
`else
        if (rom_addr !== 11'd59) begin errors++; $display("FAIL flip_right got %0d exp 59", rom_addr); end
`endif
        step(0, 1, 300, 100, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        int c, r, px, py;
        bit rs, fs, act;
        px = m_x; py = m_y;
        for (int i = 0; i < 3000; i++) begin
            rs  = ($urandom_range(0, 499) == 0);
            fs  = ($urandom_range(0, 63) == 0);
            act = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) begin
                px = $urandom_range(0, 639);
                py = $urandom_range(0, 479);
            end
            c = m_x - 8 + int'($urandom_range(0, 46));
            r = m_y - 4 + int'($urandom_range(0, 48));
            if (c < 0) c = 0;
            if (c > 1023) c = 1023;
            if (r < 0) r = 0;
            if (r > 1023) r = 1023;
            step(rs, fs && !rs, px, py, $urandom_range(0, 1) == 1, act, c, r);
            checks++;
            if (rom_addr !== 11'(m_addr)) begin
                errors++; $display("FAIL rand_addr i=%0d got %0d exp %0d", i, rom_addr, m_addr);
            end
            checks++;
            if (pixel_valid !== pv[2] || pixel_rgb !== pr[2]) begin
                errors++; $display("FAIL rand_pixel i=%0d got %0b/%0h exp %0b/%0h", i, pixel_valid, pixel_rgb, pv[2], pr[2]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; facing_left = 1'b0; active = 1'b0;
        pos_x = '0; pos_y = '0; col = '0; row = '0;
        m_run = 0; m_x = 0; m_y = 0; m_flip = 0; m_addr = 0;
        for (int i = 0; i < 3; i++) begin pv[i] = 0; pr[i] = '0; end
        for (int i = 0; i < SPR_W * SPR_H; i++)
            rom_mem[i] = ($urandom_range(0, 3) == 0) ? TR : 6'($urandom_range(0, 63));
        test_reset();
        test_no_frame();
        test_corners();
        test_transparent();
        test_right_edge();
        test_midframe();
        test_frame_coincide();
        test_flip();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
